// File: rtl/uart_rx_cfg_if.sv
// Serial receive bus: line in, received word and status flags out.
interface uart_rx_cfg_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 i_rx_serial;
  logic                 o_rx_dv;
  logic [DATA_BITS-1:0] o_rx_data;
  logic                 o_parity_err;
  logic                 o_frame_err;
  logic                 o_break;
  logic                 o_busy;

  // Receiver side.
  modport slave (
    input  i_rx_serial,
    output o_rx_dv,
    output o_rx_data,
    output o_parity_err,
    output o_frame_err,
    output o_break,
    output o_busy
  );

  // Line driver / consumer side.
  modport master (
    output i_rx_serial,
    input  o_rx_dv,
    input  o_rx_data,
    input  o_parity_err,
    input  o_frame_err,
    input  o_break,
    input  o_busy
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-FF synchroniser, start-bit glitch reject,
// 3-sample majority vote per bit, optional parity, 1 or 2 stop bits,
// frame-error and break detection.
module uart_rx_cfg #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  uart_rx_cfg_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(CLKS_PER_BIT - 3);
  localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } state_t;

  logic                 r_sync1, r_sync2;
  state_t               r_state;
  logic [CNT_W-1:0]     r_clk_cnt;
  logic [IDX_W-1:0]     r_bit_idx;
  logic                 r_samp0, r_samp1;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bit;
  logic                 r_stop_low;
  logic                 r_any_one;
  logic                 r_rx_dv;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_parity_err;
  logic                 r_frame_err;
  logic                 r_break;
  logic                 r_busy;

  state_t               w_state_nxt;
  logic [CNT_W-1:0]     w_clk_cnt_nxt;
  logic [IDX_W-1:0]     w_bit_idx_nxt;
  logic                 w_samp0_nxt, w_samp1_nxt;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 w_par_bit_nxt;
  logic                 w_stop_low_nxt;
  logic                 w_any_one_nxt;
  logic                 w_rx_dv_nxt;
  logic [DATA_BITS-1:0] w_rx_data_nxt;
  logic                 w_parity_err_nxt;
  logic                 w_frame_err_nxt;
  logic                 w_break_nxt;
  logic                 w_rx;
  logic                 w_bit;
  logic                 w_par_xor;
  logic                 w_par_err;
  logic                 w_ferr;
  logic                 w_any;

  assign w_rx      = r_sync2;
  // Third vote is the live sample taken at the last count of the bit.
  assign w_bit     = (r_samp0 & r_samp1) | (r_samp0 & w_rx) | (r_samp1 & w_rx);
  assign w_par_xor = (^r_shift) ^ r_par_bit;
  assign w_par_err = (PARITY == 1) ? ~w_par_xor :
                     (PARITY == 2) ?  w_par_xor : 1'b0;
  assign w_ferr    = r_stop_low | ~w_bit;
  assign w_any     = r_any_one | w_bit;

  // Synchroniser, FSM state and datapath registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_state      <= ST_IDLE;
      r_clk_cnt    <= '0;
      r_bit_idx    <= '0;
      r_samp0      <= 1'b1;
      r_samp1      <= 1'b1;
      r_shift      <= '0;
      r_par_bit    <= 1'b0;
      r_stop_low   <= 1'b0;
      r_any_one    <= 1'b0;
      r_rx_dv      <= 1'b0;
      r_rx_data    <= '0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_break      <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_sync1      <= bus.i_rx_serial;
      r_sync2      <= r_sync1;
      r_state      <= w_state_nxt;
      r_clk_cnt    <= w_clk_cnt_nxt;
      r_bit_idx    <= w_bit_idx_nxt;
      r_samp0      <= w_samp0_nxt;
      r_samp1      <= w_samp1_nxt;
      r_shift      <= w_shift_nxt;
      r_par_bit    <= w_par_bit_nxt;
      r_stop_low   <= w_stop_low_nxt;
      r_any_one    <= w_any_one_nxt;
      r_rx_dv      <= w_rx_dv_nxt;
      r_rx_data    <= w_rx_data_nxt;
      r_parity_err <= w_parity_err_nxt;
      r_frame_err  <= w_frame_err_nxt;
      r_break      <= w_break_nxt;
      r_busy       <= (w_state_nxt != ST_IDLE);
    end
  end

  // Next-state, bit timing, sampling and frame completion.
  always_comb begin
    w_state_nxt      = r_state;
    w_clk_cnt_nxt    = r_clk_cnt + CNT_W'(1);
    w_bit_idx_nxt    = r_bit_idx;
    w_samp0_nxt      = r_samp0;
    w_samp1_nxt      = r_samp1;
    w_shift_nxt      = r_shift;
    w_par_bit_nxt    = r_par_bit;
    w_stop_low_nxt   = r_stop_low;
    w_any_one_nxt    = r_any_one;
    w_rx_dv_nxt      = 1'b0;
    w_rx_data_nxt    = r_rx_data;
    w_parity_err_nxt = r_parity_err;
    w_frame_err_nxt  = r_frame_err;
    w_break_nxt      = r_break;

    if (r_clk_cnt == CNT_S0) w_samp0_nxt = w_rx;
    if (r_clk_cnt == CNT_S1) w_samp1_nxt = w_rx;

    unique case (r_state)
      ST_IDLE: begin
        w_clk_cnt_nxt = '0;
        if (!w_rx) begin
          w_state_nxt   = ST_START;
          w_bit_idx_nxt = '0;
        end
      end

      ST_START: begin
        if (r_clk_cnt == CNT_MID) begin
          w_clk_cnt_nxt = '0;
          if (w_rx) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt    = ST_DATA;
            w_bit_idx_nxt  = '0;
            w_shift_nxt    = '0;
            w_par_bit_nxt  = 1'b0;
            w_stop_low_nxt = 1'b0;
            w_any_one_nxt  = 1'b0;
          end
        end
      end

      ST_DATA: begin
        if (r_clk_cnt == CNT_LAST) begin
          w_clk_cnt_nxt          = '0;
          w_shift_nxt[r_bit_idx] = w_bit;
          w_any_one_nxt          = w_any;
          if (r_bit_idx == IDX_DATA_LAST) begin
            w_bit_idx_nxt = '0;
            w_state_nxt   = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + IDX_W'(1);
          end
        end
      end

      ST_PARITY: begin
        if (r_clk_cnt == CNT_LAST) begin
          w_clk_cnt_nxt = '0;
          w_par_bit_nxt = w_bit;
          w_any_one_nxt = w_any;
          w_state_nxt   = ST_STOP;
        end
      end

      ST_STOP: begin
        if (r_clk_cnt == CNT_LAST) begin
          w_clk_cnt_nxt = '0;
          if (r_bit_idx == IDX_STOP_LAST) begin
            w_rx_dv_nxt      = 1'b1;
            w_rx_data_nxt    = r_shift;
            w_parity_err_nxt = w_par_err;
            w_frame_err_nxt  = w_ferr;
            w_break_nxt      = ~w_any;
            w_bit_idx_nxt    = '0;
            w_state_nxt      = w_rx ? ST_IDLE : ST_WAIT_HIGH;
          end else begin
            w_stop_low_nxt = w_ferr;
            w_any_one_nxt  = w_any;
            w_bit_idx_nxt  = r_bit_idx + IDX_W'(1);
          end
        end
      end

      ST_WAIT_HIGH: begin
        w_clk_cnt_nxt = '0;
        if (w_rx) w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt   = ST_IDLE;
        w_clk_cnt_nxt = '0;
        w_bit_idx_nxt = '0;
      end
    endcase
  end

  assign bus.o_rx_dv      = r_rx_dv;
  assign bus.o_rx_data    = r_rx_data;
  assign bus.o_parity_err = r_parity_err;
  assign bus.o_frame_err  = r_frame_err;
  assign bus.o_break      = r_break;
  assign bus.o_busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: 8N1, 8E1 and 7O2 receivers driven with directed and
// random frames, compared against a frame-level model of the expected result.
module tb_uart_rx_cfg;

  localparam int unsigned CPB = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic line [3];

  int total = 0;
  int bad   = 0;
  int exp_cnt [3] = '{0, 0, 0};
  int dv_cnt  [3] = '{0, 0, 0};
  int nb [3] = '{8, 8, 7};
  int pm [3] = '{0, 2, 1};
  int ns [3] = '{1, 1, 2};

  typedef struct {
    logic [8:0] data;
    logic       dv;
    logic       pe;
    logic       fe;
    logic       brk;
    logic       busy;
  } obs_t;

  always #5 clk = ~clk;

  uart_rx_cfg_if #(.DATA_BITS(8)) if0 ();
  uart_rx_cfg_if #(.DATA_BITS(8)) if1 ();
  uart_rx_cfg_if #(.DATA_BITS(7)) if2 ();

  assign if0.i_rx_serial = line[0];
  assign if1.i_rx_serial = line[1];
  assign if2.i_rx_serial = line[2];

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(if0.slave));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(if1.slave));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_7o2 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(if2.slave));

  // Count every cycle the data-valid strobe is high on each receiver.
  always @(negedge clk) begin
    if (if0.o_rx_dv) dv_cnt[0]++;
    if (if1.o_rx_dv) dv_cnt[1]++;
    if (if2.o_rx_dv) dv_cnt[2]++;
  end

  function automatic obs_t get_obs(input int sel);
    obs_t o;
    case (sel)
      0: o = '{9'(if0.o_rx_data), if0.o_rx_dv, if0.o_parity_err, if0.o_frame_err, if0.o_break, if0.o_busy};
      1: o = '{9'(if1.o_rx_data), if1.o_rx_dv, if1.o_parity_err, if1.o_frame_err, if1.o_break, if1.o_busy};
      default: o = '{9'(if2.o_rx_data), if2.o_rx_dv, if2.o_parity_err, if2.o_frame_err, if2.o_break, if2.o_busy};
    endcase
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input int sel, input logic v, input int n);
    line[sel] = v;
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame; gbit selects a data bit that gets a one-cycle inversion.
  task automatic send_frame(input int sel, input logic [8:0] d, input logic pbit,
                            input logic [1:0] st, input int gbit);
    hold(sel, 1'b0, CPB);
    for (int i = 0; i < nb[sel]; i++) begin
      if (i == gbit) begin
        hold(sel, d[i], 7);
        hold(sel, ~d[i], 1);
        hold(sel, d[i], 8);
      end else begin
        hold(sel, d[i], CPB);
      end
    end
    if (pm[sel] != 0) hold(sel, pbit, CPB);
    for (int i = 0; i < ns[sel]; i++) hold(sel, st[i], CPB);
  endtask

  // Expected result of a frame from its bit content alone.
  task automatic model(input int sel, input logic [8:0] d, input logic pbit, input logic [1:0] st,
                       output logic [8:0] ed, output logic epe, output logic efe, output logic ebk);
    int   ones;
    logic allz;
    ed = d;
    for (int i = nb[sel]; i < 9; i++) ed[i] = 1'b0;
    ones = $countones(ed) + ((pm[sel] != 0 && pbit) ? 1 : 0);
    if (pm[sel] == 1)      epe = (ones % 2 == 0);
    else if (pm[sel] == 2) epe = (ones % 2 == 1);
    else                   epe = 1'b0;
    efe  = 1'b0;
    allz = 1'b1;
    for (int i = 0; i < ns[sel]; i++) begin
      if (!st[i]) efe = 1'b1;
      else        allz = 1'b0;
    end
    ebk = (ed == 9'd0) && (pm[sel] == 0 || !pbit) && allz;
  endtask

  task automatic run_frame(input string tag, input int sel, input logic [8:0] d, input logic pbit,
                           input logic [1:0] st, input int gbit, input int gap);
    logic [8:0] ed;
    logic       epe, efe, ebk;
    obs_t       o;
    send_frame(sel, d, pbit, st, gbit);
    hold(sel, 1'b1, gap);
    model(sel, d, pbit, st, ed, epe, efe, ebk);
    exp_cnt[sel]++;
    o = get_obs(sel);
    chk({tag, "_dvcnt"}, dv_cnt[sel], exp_cnt[sel]);
    chk({tag, "_data"},  o.data, ed);
    chk({tag, "_perr"},  o.pe,   epe);
    chk({tag, "_ferr"},  o.fe,   efe);
    chk({tag, "_brk"},   o.brk,  ebk);
    chk({tag, "_busy"},  o.busy, 1'b0);
  endtask

  initial begin
    obs_t       o;
    int         sel;
    logic [8:0] d;
    logic       pbit;
    logic [1:0] st;
    int         gap;

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) line[i] = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      o = get_obs(s);
      chk($sformatf("rst%0d_data", s), o.data, 9'd0);
      chk($sformatf("rst%0d_dv", s),   o.dv,   1'b0);
      chk($sformatf("rst%0d_flags", s), {o.pe, o.fe, o.brk}, 3'b000);
      chk($sformatf("rst%0d_busy", s), o.busy, 1'b0);
    end
    rst_n = 1'b1;
    hold(0, 1'b1, 4);

    run_frame("8n1_a5", 0, 9'h0A5, 1'b0, 2'b11, -1, 6);
    run_frame("8e1_par1", 1, 9'h03C, 1'b1, 2'b11, -1, 6);
    run_frame("8e1_par0", 1, 9'h03C, 1'b0, 2'b11, -1, 6);
    run_frame("7o2_stop2lo", 2, 9'h055, 1'b1, 2'b01, -1, 6);
    run_frame("glitch_f0", 0, 9'h0F0, 1'b0, 2'b11, 3, 6);

    // Short low pulse is rejected at the start-bit midpoint.
    hold(0, 1'b0, 4);
    o = get_obs(0);
    chk("short_busy_hi", o.busy, 1'b1);
    hold(0, 1'b0, 1);
    hold(0, 1'b1, 20);
    o = get_obs(0);
    chk("short_busy_lo", o.busy, 1'b0);
    chk("short_dvcnt", dv_cnt[0], exp_cnt[0]);

    // Line held low for 40 bit times: one break frame, then wait for high.
    hold(0, 1'b0, 40 * CPB);
    exp_cnt[0]++;
    o = get_obs(0);
    chk("brk_dvcnt", dv_cnt[0], exp_cnt[0]);
    chk("brk_data", o.data, 9'd0);
    chk("brk_brk", o.brk, 1'b1);
    chk("brk_ferr", o.fe, 1'b1);
    chk("brk_busy_hi", o.busy, 1'b1);
    hold(0, 1'b1, 6);
    o = get_obs(0);
    chk("brk_busy_lo", o.busy, 1'b0);
    hold(0, 1'b1, 40);
    chk("brk_dvcnt_after", dv_cnt[0], exp_cnt[0]);

    // Reset in the middle of data bit 4 aborts the frame.
    d = 9'h05A;
    hold(0, 1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(0, d[i], CPB);
    hold(0, d[4], 8);
    rst_n   = 1'b0;
    line[0] = 1'b1;
    repeat (2) @(negedge clk);
    o = get_obs(0);
    chk("rstmid_busy", o.busy, 1'b0);
    chk("rstmid_data", o.data, 9'd0);
    rst_n = 1'b1;
    hold(0, 1'b1, 20 * CPB);
    chk("rstmid_dvcnt", dv_cnt[0], exp_cnt[0]);
    run_frame("after_rst_81", 0, 9'h081, 1'b0, 2'b11, -1, 6);

    // Random frames, including stop-bit errors, breaks and zero-gap sequences.
    for (int k = 0; k < 36; k++) begin
      sel  = int'($urandom_range(0, 2));
      d    = 9'($urandom);
      pbit = 1'($urandom);
      st[0] = ($urandom_range(0, 3) != 0);
      st[1] = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        d    = 9'd0;
        pbit = 1'b0;
        st   = 2'b00;
      end
      gap = st[ns[sel] - 1] ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 8));
      run_frame($sformatf("rnd%0d", k), sel, d, pbit, st, -1, gap);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
